pipe_ctrl_chain: RTL and testbench

- Parametrised successor to the single-stage control-signal pipeline register.
- Carries a WIDTH-bit control bundle through DEPTH elastic stages, each with its own valid bit.
- Provides valid/ready backpressure with bubble collapse, a global stall, and a flush that forces NOP (RESET_VAL) bubbles.
- Sits between decode and execute/writeback control paths, including the UART-attached core, wherever multi-cycle latency or hazard flushing is needed.

---
 rtl/pipe_ctrl_chain_if.sv | 28 ++
 rtl/pipe_ctrl_chain.sv | 97 +++++++++
 tb/tb_pipe_ctrl_chain.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_chain_if.sv
// Handshake, stall/flush and occupancy bundle for the control-signal pipeline chain.
// Valid/ready: a transfer fires on a cycle where valid and ready are both 1 at the rising edge.
interface pipe_ctrl_chain_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             stall;
  logic             flush;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready, stall, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, stall, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// DEPTH-stage elastic pipeline for a WIDTH-bit control bundle with bubble collapse,
// global stall and a flush that refills every stage with the RESET_VAL NOP encoding.
module pipe_ctrl_chain #(
  parameter int               WIDTH     = 5,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  pipe_ctrl_chain_if.slave    bus,
  output logic [DEPTH-1:0]    dbg_valid
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             rdy_out;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             hold;
  logic             push;
  logic             pop;

  assign hold = bus.stall | bus.flush;

  // A stage can take new data if it is empty or everything downstream moves.
  always_comb begin : ready_chain
    logic r;
    rdy_out = bus.out_ready & ~hold;
    r       = rdy_out;
    rdy     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = ~valid_q[i] | r;
      rdy[i] = r;
    end
  end

  assign bus.in_ready  = rdy[0] & ~hold & ~reset;
  assign bus.out_valid = valid_q[DEPTH-1] & ~hold;
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.occupancy = occ_q;
  assign dbg_valid     = valid_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      data_d[i]  = data_q[i];
      if (bus.flush) begin
        valid_d[i] = 1'b0;
        data_d[i]  = RESET_VAL;
      end else if (!bus.stall && rdy[i]) begin
        // Bubbles always carry the NOP encoding.
        valid_d[i] = src_valid[i];
        data_d[i]  = src_valid[i] ? src_data[i] : RESET_VAL;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (bus.flush) begin
      occ_d = '0;
    end else if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Self-checking bench for pipe_ctrl_chain (WIDTH=5, DEPTH=3) with a FIFO scoreboard
// that also models occupancy as the number of bundles in flight.
module tb_pipe_ctrl_chain;
  localparam int WIDTH = 5;
  localparam int DEPTH = 3;
  localparam logic [WIDTH-1:0] NOP = '0;

  logic             clk = 1'b0;
  logic             reset;
  logic [DEPTH-1:0] dbg_valid;

  int               n_cmp  = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_v;

  pipe_ctrl_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_ctrl_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_valid (dbg_valid)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      n_cmp++;
      if (int'(bus.occupancy) !== exp_q.size()) begin
        n_fail++;
        $display("FAIL occupancy_model: got %0d, required %0d", bus.occupancy, exp_q.size());
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        if (bus.out_data !== NOP) begin
          n_fail++;
          $display("FAIL empty_out_data: got %h, required %h", bus.out_data, NOP);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pop: got %h, required no output", bus.out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.out_data !== exp_v) begin
            n_fail++;
            $display("FAIL pop_data: got %h, required %h", bus.out_data, exp_v);
          end
        end
      end
      if (bus.flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic st, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.stall     = st;
    bus.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [WIDTH-1:0] tbl [3];
    bit ok;
    tbl = '{5'h11, 5'h0A, 5'h1F};
    reset = 1'b1;
    drive(0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 5'h03, 0, 0, 0);
    step();
    drive(1, 5'h04, 0, 0, 0);
    step();
    drive(0, '0, 0, 0, 0);
    @(posedge clk);
    #2;
    n_cmp++;
    if (bus.occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_reset_occ: got %0d, required 2", bus.occupancy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== NOP || bus.occupancy !== 2'd0 ||
        bus.in_ready !== 1'b0 || dbg_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b d=%h occ=%0d rdy=%b stages=%b, required 0 00 0 0 000",
               bus.out_valid, bus.out_data, bus.occupancy, bus.in_ready, dbg_valid);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset: got rdy=%b occ=%0d, required rdy=1 occ=0",
               bus.in_ready, bus.occupancy);
    end
    drive(1, 5'h11, 1, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1)      drive(1, 5'h0A, 1, 0, 0);
      else if (c == 2) drive(1, 5'h1F, 1, 0, 0);
      else             drive(0, '0, 1, 0, 0);
      @(negedge clk);
      if (c >= 3) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== tbl[c-3]) begin
          n_fail++;
          $display("FAIL stream_latency c%0d: got v=%b d=%h, required v=1 d=%h",
                   c, bus.out_valid, bus.out_data, tbl[c-3]);
        end
      end
    end
    wait_empty(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_stream: got %0d entries left, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int k = 0; k < 4; k++) begin
      drive(1, WIDTH'(k + 1), 0, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== (k < 3)) begin
        n_fail++;
        $display("FAIL fill_in_ready k%0d: got %b, required %b", k, bus.in_ready, (k < 3));
      end
      step();
    end
    n_cmp++;
    if (bus.occupancy !== 2'd3 || dbg_valid !== 3'b111 || bus.out_data !== 5'h01) begin
      n_fail++;
      $display("FAIL full_state: got occ=%0d stages=%b d=%h, required 3 111 01",
               bus.occupancy, dbg_valid, bus.out_data);
    end
    drive(1, 5'h04, 1, 0, 0);
    step();
    drive(0, '0, 1, 0, 0);
    wait_empty(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_backpressure: got %0d entries left, required 0", exp_q.size());
    end
  endtask

  task automatic test_bubble_collapse();
    bit ok;
    drive(1, 5'h05, 0, 0, 0);
    step();
    drive(0, '0, 0, 0, 0);
    repeat (2) step();
    drive(1, 5'h06, 0, 0, 0);
    step();
    drive(0, '0, 0, 0, 0);
    repeat (3) step();
    n_cmp++;
    if (bus.occupancy !== 2'd2 || dbg_valid !== 3'b110 || bus.out_data !== 5'h05 ||
        bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bubble_collapse: got occ=%0d stages=%b v=%b d=%h, required 2 110 1 05",
               bus.occupancy, dbg_valid, bus.out_valid, bus.out_data);
    end
    drive(0, '0, 1, 0, 0);
    wait_empty(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_bubble: got %0d entries left, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    bit ok;
    drive(1, 5'h08, 0, 0, 0);
    step();
    drive(1, 5'h09, 0, 0, 0);
    step();
    drive(0, '0, 0, 0, 0);
    repeat (3) step();
    drive(1, 5'h0C, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.occupancy !== 2'd2 ||
          dbg_valid !== 3'b110 || bus.out_data !== 5'h08) begin
        n_fail++;
        $display("FAIL stall_hold k%0d: got rdy=%b v=%b occ=%0d stages=%b d=%h, required 0 0 2 110 08",
                 k, bus.in_ready, bus.out_valid, bus.occupancy, dbg_valid, bus.out_data);
      end
      step();
    end
    drive(0, '0, 1, 0, 0);
    wait_empty(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_stall: got %0d entries left, required 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1, WIDTH'(5'h12 + k), 0, 0, 0);
      step();
    end
    drive(1, 5'h1E, 0, 1, 1);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_gate: got rdy=%b v=%b, required 0 0", bus.in_ready, bus.out_valid);
    end
    step();
    drive(0, '0, 0, 0, 0);
    n_cmp++;
    if (bus.occupancy !== 2'd0 || bus.out_data !== NOP || bus.out_valid !== 1'b0 ||
        dbg_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_result: got occ=%0d d=%h v=%b stages=%b, required 0 00 0 000",
               bus.occupancy, bus.out_data, bus.out_valid, dbg_valid);
    end
    drive(0, '0, 1, 0, 0);
    repeat (5) step();
  endtask

  task automatic test_push_pop_full();
    int  pops;
    int  idx;
    bit  ok;
    for (int k = 0; k < 3; k++) begin
      drive(1, WIDTH'(5'h15 + k), 0, 0, 0);
      step();
    end
    drive(1, 5'h07, 1, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 5'h15) begin
      n_fail++;
      $display("FAIL full_swap: got rdy=%b v=%b d=%h, required 1 1 15",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    pops = 1;
    idx  = -1;
    step();
    drive(0, '0, 1, 0, 0);
    n_cmp++;
    if (bus.occupancy !== 2'd3) begin
      n_fail++;
      $display("FAIL full_swap_occ: got %0d, required 3", bus.occupancy);
    end
    for (int i = 0; i < 10 && idx < 0; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (bus.out_data === 5'h07) idx = pops;
      end
    end
    n_cmp++;
    if (idx !== 4) begin
      n_fail++;
      $display("FAIL swap_entry_pos: got pop %0d, required pop 4", idx);
    end
    wait_empty(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_swap: got %0d entries left, required 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), WIDTH'($urandom_range(0, 31)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 39) == 0));
      step();
    end
    drive(0, '0, 1, 0, 0);
    wait_empty(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_random: got %0d entries left, required 0", exp_q.size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_backpressure();
    test_bubble_collapse();
    test_stall();
    test_flush();
    test_push_pop_full();
    test_random();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
